// File: rtl/mem_stage_pkg.sv
// Shared definitions for the byte-serial load/store stage.
package mem_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 5;

    typedef logic [AluOpBus-1:0] aluop_t;

    localparam aluop_t EXE_NOP_OP = 5'h00;
    localparam aluop_t EXE_LB_OP  = 5'h01;
    localparam aluop_t EXE_LH_OP  = 5'h02;
    localparam aluop_t EXE_LW_OP  = 5'h03;
    localparam aluop_t EXE_LBU_OP = 5'h04;
    localparam aluop_t EXE_LHU_OP = 5'h05;
    localparam aluop_t EXE_SB_OP  = 5'h06;
    localparam aluop_t EXE_SH_OP  = 5'h07;
    localparam aluop_t EXE_SW_OP  = 5'h08;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_FINISH = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    function automatic logic op_is_load(aluop_t op);
        return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
               (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
    endfunction

    function automatic logic op_is_store(aluop_t op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    // Index of the final byte of the access: 0 for byte, 1 for half, 3 for word.
    function automatic logic [1:0] op_last_byte(aluop_t op);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2'd1;
            EXE_LW_OP, EXE_SW_OP:             return 2'd3;
            default:                          return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide memory request/grant bus between the MEM stage and data memory.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [RegBus-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              mem_gnt_i;
    logic [7:0]        mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_stage_load_extend.sv
// Assembles the gathered load bytes into a register value with sign/zero extension.
module load_extend
    import mem_stage_pkg::*;
(
    input  aluop_t             aluop_i,
    input  logic [3:0][7:0]    bytes_i,
    output logic [RegBus-1:0]  data_o
);

    // Select width and extension from the op; non-load ops yield zero.
    always_comb begin
        data_o = '0;
        case (aluop_i)
            EXE_LB_OP:  data_o = {{24{bytes_i[0][7]}}, bytes_i[0]};
            EXE_LBU_OP: data_o = {24'h0, bytes_i[0]};
            EXE_LH_OP:  data_o = {{16{bytes_i[1][7]}}, bytes_i[1], bytes_i[0]};
            EXE_LHU_OP: data_o = {16'h0, bytes_i[1], bytes_i[0]};
            EXE_LW_OP:  data_o = bytes_i;
            default:    data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores over an 8-bit bus, with
// pass-through for non-memory ops and a stall request while busy.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  aluop_t                aluop_i,
    input  logic                  w_enable_i,
    input  logic [RegAddrBus-1:0] w_addr_i,
    input  logic [RegBus-1:0]     w_data_i,
    input  logic [RegBus-1:0]     ram_addr_i,
    input  logic [RegBus-1:0]     store_data_i,
    mem_stage_if.master           bus,
    output logic                  w_enable_o,
    output logic [RegAddrBus-1:0] w_addr_o,
    output logic [RegBus-1:0]     w_data_o,
    output logic                  mem_stall_req_o
);

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [3:0][7:0] lbuf_q;
    logic            pend_q;       // a load byte was granted last cycle
    logic [1:0]      pend_lane_q;  // lane that byte belongs to
    logic [RegBus-1:0] ext_data;

    logic is_load, is_store, is_mem;
    logic [1:0] last;

    assign is_load  = op_is_load(aluop_i);
    assign is_store = op_is_store(aluop_i);
    assign is_mem   = is_load | is_store;
    assign last     = op_last_byte(aluop_i);

    load_extend u_load_extend (
        .aluop_i (aluop_i),
        .bytes_i (lbuf_q),
        .data_o  (ext_data)
    );

    // Next-state and byte counter; the counter only advances on a grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (is_mem) begin
                    cnt_d   = 2'd0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.mem_gnt_i) begin
                    if (cnt_q == last) state_d = is_load ? S_FINISH : S_DONE;
                    else               cnt_d   = cnt_q + 2'd1;
                end
            end
            S_FINISH: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read data trails its grant by one cycle, so remember the lane and land it next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_lane_q <= 2'd0;
            lbuf_q      <= '0;
        end else begin
            pend_q      <= (state_q == S_ACCESS) && bus.mem_gnt_i && is_load;
            pend_lane_q <= cnt_q;
            if (pend_q) lbuf_q[pend_lane_q] <= bus.mem_rdata_i;
        end
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        w_enable_o      = 1'b0;
        w_addr_o        = '0;
        w_data_o        = '0;
        mem_stall_req_o = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (is_mem) begin
                        mem_stall_req_o = 1'b1;
                    end else begin
                        w_enable_o = w_enable_i;
                        w_addr_o   = w_addr_i;
                        w_data_o   = w_data_i;
                    end
                end
                S_ACCESS: begin
                    mem_stall_req_o = 1'b1;
                    bus.mem_req_o   = 1'b1;
                    bus.mem_we_o    = is_store;
                    bus.mem_addr_o  = ram_addr_i + {30'd0, cnt_q};
                    bus.mem_wdata_o = store_data_i[{cnt_q, 3'b000} +: 8];
                end
                S_FINISH: mem_stall_req_o = 1'b1;
                S_DONE: begin
                    if (is_load) begin
                        w_enable_o = w_enable_i;
                        w_addr_o   = w_addr_i;
                        w_data_o   = ext_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aluop_t                aluop_i;
    logic                  w_enable_i;
    logic [RegAddrBus-1:0] w_addr_i;
    logic [RegBus-1:0]     w_data_i, ram_addr_i, store_data_i;
    logic                  w_enable_o;
    logic [RegAddrBus-1:0] w_addr_o;
    logic [RegBus-1:0]     w_data_o;
    logic                  mem_stall_req_o;

    mem_stage_if mem_bus ();

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .aluop_i         (aluop_i),
        .w_enable_i      (w_enable_i),
        .w_addr_i        (w_addr_i),
        .w_data_i        (w_data_i),
        .ram_addr_i      (ram_addr_i),
        .store_data_i    (store_data_i),
        .bus             (mem_bus),
        .w_enable_o      (w_enable_o),
        .w_addr_o        (w_addr_o),
        .w_data_o        (w_data_o),
        .mem_stall_req_o (mem_stall_req_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] ram [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] memrd(input logic [31:0] a);
        if (!ram.exists(a)) ram[a] = 8'($urandom);
        return ram[a];
    endfunction

    function automatic int nbytes(input aluop_t op);
        if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        return 1;
    endfunction

    function automatic bit is_ld(input aluop_t op);
        return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
    endfunction

    // Little-endian value of n bytes, then signed ops subtract 2^width when the top bit is set.
    function automatic logic [31:0] ref_load(input aluop_t op, input logic [31:0] a);
        logic [31:0] v;
        v = 0;
        for (int k = 0; k < nbytes(op); k++) v = v + (32'(memrd(a + k)) << (8 * k));
        if (op == EXE_LB_OP && v >= 128)   v = v - 32'd256;
        if (op == EXE_LH_OP && v >= 32768) v = v - 32'd65536;
        return v;
    endfunction

    task automatic idle_inputs();
        aluop_i = EXE_NOP_OP; w_enable_i = 0; w_addr_i = 0; w_data_i = 0;
        ram_addr_i = 0; store_data_i = 0;
        mem_bus.mem_gnt_i = 0; mem_bus.mem_rdata_i = 0;
    endtask

    // Drive one memory op from IDLE until stall drops; mode 0 grant always,
    // 1 random grant, 2 grant withheld three cycles before byte 2.
    task automatic run_op(input string tag, input aluop_t op, input logic [31:0] addr,
                          input logic [31:0] sdata, input int mode);
        int n, cyc, nstall, nwb, lows, ngnt;
        bit ld, pend, done, g;
        logic [31:0] exp_wb, paddr, wb_data;
        logic [4:0] wa, wb_addr;
        n = nbytes(op); ld = is_ld(op);
        exp_wb = ld ? ref_load(op, addr) : 32'h0;
        wa = 5'($urandom);
        cyc = 0; nstall = 0; nwb = 0; lows = 0; ngnt = 0;
        pend = 0; done = 0; paddr = 0; wb_data = 0; wb_addr = 0;
        aluop_i = op; ram_addr_i = addr; store_data_i = sdata;
        w_enable_i = 1; w_addr_i = wa; w_data_i = $urandom;
        while (!done && cyc < 40) begin
            if (mode == 0)      g = 1;
            else if (mode == 2) g = !(ngnt == 2 && lows < 3);
            else                g = ($urandom_range(0, 3) != 0);
            mem_bus.mem_gnt_i   = g;
            mem_bus.mem_rdata_i = pend ? memrd(paddr) : 8'($urandom);
            #4;
            cyc++;
            pend = 0;
            if (mem_bus.mem_req_o) begin
                check({tag, "_addr"}, mem_bus.mem_addr_o, addr + ngnt);
                check({tag, "_we"}, 32'(mem_bus.mem_we_o), 32'(!ld));
                if (!ld) check({tag, "_wdata"}, 32'(mem_bus.mem_wdata_o), (sdata >> (8 * ngnt)) & 32'hFF);
                if (g) begin
                    if (mem_bus.mem_we_o) ram[mem_bus.mem_addr_o] = mem_bus.mem_wdata_o;
                    else begin pend = 1; paddr = mem_bus.mem_addr_o; end
                    ngnt++;
                end else lows++;
            end
            if (mem_stall_req_o) nstall++;
            if (w_enable_o) begin nwb++; wb_data = w_data_o; wb_addr = w_addr_o; end
            if (!mem_stall_req_o) done = 1;
            @(posedge clk); #1;
        end
        idle_inputs();
        check({tag, "_cycles"}, 32'(cyc), 32'(2 + n + int'(ld) + lows));
        check({tag, "_stall"}, 32'(nstall), 32'(cyc - 1));
        check({tag, "_grants"}, 32'(ngnt), 32'(n));
        check({tag, "_wbcount"}, 32'(nwb), 32'(ld));
        if (ld) begin
            check({tag, "_wbdata"}, wb_data, exp_wb);
            check({tag, "_wbaddr"}, 32'(wb_addr), 32'(wa));
        end
    endtask

    aluop_t ops [8] = '{EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP,
                        EXE_LHU_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

    initial begin
        int bad;
        rst = 1;
        idle_inputs();
        aluop_i = 5'h09; w_enable_i = 1; w_addr_i = 5'd5; w_data_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        #4;
        check("rst_wen", 32'(w_enable_o), 0);
        check("rst_wdata", w_data_o, 0);
        check("rst_stall", 32'(mem_stall_req_o), 0);
        check("rst_req", 32'(mem_bus.mem_req_o), 0);
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        #4;
        check("post_rst_outs", {w_enable_o, w_addr_o, mem_stall_req_o, mem_bus.mem_req_o,
                                mem_bus.mem_we_o, mem_bus.mem_wdata_o}, 0);
        check("post_rst_addr", mem_bus.mem_addr_o, 0);
        @(posedge clk); #1;

        // Non-memory ops pass straight through with no stall.
        for (int i = 0; i < 6; i++) begin
            aluop_i = (i == 0) ? EXE_NOP_OP : aluop_t'($urandom_range(9, 31));
            w_enable_i = 1'($urandom); w_addr_i = 5'($urandom); w_data_i = $urandom;
            #4;
            check("pt_wen", 32'(w_enable_o), 32'(w_enable_i));
            check("pt_waddr", 32'(w_addr_o), 32'(w_addr_i));
            check("pt_wdata", w_data_o, w_data_i);
            check("pt_stall_req", {mem_stall_req_o, mem_bus.mem_req_o}, 0);
            @(posedge clk); #1;
        end
        idle_inputs();

        ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
        check("lw_model", ref_load(EXE_LW_OP, 32'h100), 32'h12345678);
        run_op("lw100", EXE_LW_OP, 32'h100, 0, 0);
        ram[32'h3] = 8'h80;
        check("lb_model", ref_load(EXE_LB_OP, 32'h3), 32'hFFFFFF80);
        run_op("lb3", EXE_LB_OP, 32'h3, 0, 0);
        run_op("lbu3", EXE_LBU_OP, 32'h3, 0, 0);
        run_op("sh201", EXE_SH_OP, 32'h201, 32'hAABBCCDD, 0);
        check("sh_mem", {ram[32'h202], ram[32'h201]}, 32'h0000CCDD);
        run_op("sw_hold", EXE_SW_OP, 32'h300, 32'h11223344, 2);
        check("sw_mem", {ram[32'h303], ram[32'h302], ram[32'h301], ram[32'h300]}, 32'h11223344);
        run_op("lw_wrap", EXE_LW_OP, 32'hFFFFFFFE, 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFFFFFC + $urandom_range(0, 3));
            run_op("rnd", ops[$urandom_range(0, 7)], a, $urandom, 1);
        end

        // Abort a word load mid-access.
        aluop_i = EXE_LW_OP; ram_addr_i = 32'h40; w_enable_i = 1; w_addr_i = 5'd7;
        mem_bus.mem_gnt_i = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #4;
        check("abort_pre_req", 32'(mem_bus.mem_req_o), 1);
        rst = 1;
        #1;
        check("abort_rst_outs", {mem_bus.mem_req_o, mem_stall_req_o, w_enable_o}, 0);
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        #4;
        check("abort_idle_outs", {w_enable_o, w_addr_o, mem_stall_req_o, mem_bus.mem_req_o,
                                  mem_bus.mem_we_o, mem_bus.mem_wdata_o}, 0);
        check("abort_idle_data", w_data_o, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #5;
            if (mem_bus.mem_req_o || w_enable_o || mem_stall_req_o) bad++;
        end
        check("abort_quiet", 32'(bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
